sample_frame_streamer: RTL and testbench

SAMPLE_FRAME_STREAMER -- requirements
Module: sample_frame_streamer

---
 rtl/mic_pkg.sv | 23 ++
 rtl/sample_abs_dev.sv | 22 ++
 rtl/sample_frame_streamer.sv | 187 ++++++++++++++++++
 tb/tb_sample_frame_streamer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mic_pkg.sv
// mic_pkg -- shared definitions for the microphone sample front end.
//   N_SAMPLES_DEFAULT / SAMPLE_W_DEFAULT : default window depth and ADC width
//   midscale_of()                        : ADC mid-code for a given width
//   MIDSCALE                             : mid-code at the default width
//   stream_state_e                       : IDLE / STREAM frame streamer states
package mic_pkg;

  localparam int N_SAMPLES_DEFAULT = 16;
  localparam int SAMPLE_W_DEFAULT  = 12;

  // Unsigned ADC samples are centred on the mid-code 2^(width-1).
  function automatic int unsigned midscale_of(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

  localparam int unsigned MIDSCALE = midscale_of(SAMPLE_W_DEFAULT);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } stream_state_e;

endpackage

// File: rtl/sample_abs_dev.sv
// sample_abs_dev -- distance of an unsigned ADC sample from mid-scale.
//   sample : SAMPLE_W-bit unsigned sample
//   dev    : |sample - 2^(SAMPLE_W-1)|, SAMPLE_W bits (0 maps to the full mid-code)
// Purely combinational.
module sample_abs_dev
  import mic_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEFAULT
) (
  input  logic [SAMPLE_W-1:0] sample,
  output logic [SAMPLE_W-1:0] dev
);

  // Equals MIDSCALE when SAMPLE_W is the default width.
  localparam logic [SAMPLE_W-1:0] MID = SAMPLE_W'(midscale_of(SAMPLE_W));

  always_comb begin
    if (sample >= MID) dev = sample - MID;
    else               dev = MID - sample;
  end

endmodule

// File: rtl/sample_frame_streamer.sv
// sample_frame_streamer -- snapshots a sliding sample window every HOP new
// samples and streams it out one sample per handshake, reporting the peak
// deviation from mid-scale of each completed frame.
//   clk_10MHz, rst       : clock, asynchronous active-high reset
//   samples, sample_tick : sliding window (index 0 oldest) and new-sample pulse
//   enable               : capture enable (a running frame always completes)
//   out_data/out_idx/out_valid/out_ready/out_first/out_last : sample stream
//   frame_peak, peak_valid : per-frame max deviation, one-cycle valid pulse
//   busy, overrun, drop_count, clear_overrun : status and dropped-frame tally
module sample_frame_streamer
  import mic_pkg::*;
#(
  parameter int N_SAMPLES = N_SAMPLES_DEFAULT,
  parameter int SAMPLE_W  = SAMPLE_W_DEFAULT,
  parameter int HOP       = 16
) (
  input  logic                               clk_10MHz,
  input  logic                               rst,
  input  logic [N_SAMPLES-1:0][SAMPLE_W-1:0] samples,
  input  logic                               sample_tick,
  input  logic                               enable,
  output logic [SAMPLE_W-1:0]                out_data,
  output logic [$clog2(N_SAMPLES)-1:0]       out_idx,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_first,
  output logic                               out_last,
  output logic [SAMPLE_W-1:0]                frame_peak,
  output logic                               peak_valid,
  output logic                               busy,
  output logic                               overrun,
  output logic [7:0]                         drop_count,
  input  logic                               clear_overrun
);

  localparam int IDX_W  = $clog2(N_SAMPLES);
  localparam int FILL_W = $clog2(N_SAMPLES + 1);
  localparam int HOP_W  = (HOP > 1) ? $clog2(HOP) : 1;

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N_SAMPLES);
  localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(N_SAMPLES - 1);
  localparam logic [HOP_W-1:0]  HOP_LAST  = HOP_W'(HOP - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_SAMPLES - 1);

  stream_state_e      state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [FILL_W-1:0]  fill_reg;
  logic [HOP_W-1:0]   hop_reg;
  logic [SAMPLE_W-1:0] frame_buf [N_SAMPLES];
  logic [SAMPLE_W-1:0] peak_acc_reg, frame_peak_reg, cur_dev, peak_max;
  logic               peak_valid_reg, overrun_reg;
  logic [7:0]         drop_count_reg, drop_base;
  logic               trigger, handshake, capture, drop, frame_done;

  // ---------------- tick counters ----------------
  // The fill counter only has to reach N_SAMPLES-1 for the trigger; it
  // saturates so a long run never wraps back into the "not yet full" range.
  always_ff @(posedge clk_10MHz or posedge rst) begin
    if (rst) begin
      fill_reg <= '0;
      hop_reg  <= '0;
    end else if (!enable) begin
      fill_reg <= '0;
      hop_reg  <= '0;
    end else if (sample_tick) begin
      if (fill_reg != FILL_FULL) fill_reg <= fill_reg + 1'b1;
      hop_reg <= (hop_reg == HOP_LAST) ? '0 : hop_reg + 1'b1;
    end
  end

  assign trigger = enable && sample_tick && (fill_reg >= FILL_ARM) && (hop_reg == HOP_LAST);

  // ---------------- FSM ----------------
  always_ff @(posedge clk_10MHz or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  assign out_valid = (state_reg == STREAM);
  assign handshake = out_valid && out_ready;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    capture    = 1'b0;
    drop       = 1'b0;
    frame_done = 1'b0;
    case (state_reg)
      IDLE: begin
        if (trigger) begin
          capture    = 1'b1;
          state_next = STREAM;
          idx_next   = '0;
        end
      end
      STREAM: begin
        if (handshake) begin
          if (idx_reg == IDX_LAST) begin
            frame_done = 1'b1;
            idx_next   = '0;
            // A trigger landing on the final handshake chains straight
            // into the next frame instead of being dropped.
            if (trigger) capture = 1'b1;
            else         state_next = IDLE;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
        if (trigger && !(handshake && idx_reg == IDX_LAST)) drop = 1'b1;
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // ---------------- frame buffer ----------------
  // Contents are only observable while streaming, so no reset is needed.
  for (genvar gi = 0; gi < N_SAMPLES; gi++) begin : g_buf
    always_ff @(posedge clk_10MHz) begin
      if (capture) frame_buf[gi] <= samples[gi];
    end
  end

  assign out_data  = out_valid ? frame_buf[idx_reg] : '0;
  assign out_idx   = idx_reg;
  assign out_first = out_valid && (idx_reg == '0);
  assign out_last  = out_valid && (idx_reg == IDX_LAST);
  assign busy      = out_valid;

  // ---------------- peak tracking ----------------
  sample_abs_dev #(.SAMPLE_W(SAMPLE_W)) u_abs_dev (
    .sample (out_data),
    .dev    (cur_dev)
  );

  assign peak_max = (cur_dev > peak_acc_reg) ? cur_dev : peak_acc_reg;

  always_ff @(posedge clk_10MHz or posedge rst) begin
    if (rst) begin
      peak_acc_reg   <= '0;
      frame_peak_reg <= '0;
      peak_valid_reg <= 1'b0;
    end else begin
      peak_valid_reg <= frame_done;
      if (frame_done) begin
        frame_peak_reg <= peak_max;
        peak_acc_reg   <= '0;
      end else if (handshake) begin
        peak_acc_reg <= peak_max;
      end else if (capture) begin
        peak_acc_reg <= '0;
      end
    end
  end

  assign frame_peak = frame_peak_reg;
  assign peak_valid = peak_valid_reg;

  // ---------------- overrun accounting ----------------
  // Clearing rebases the counter to zero first, so a simultaneous drop
  // leaves exactly one drop recorded.
  assign drop_base = clear_overrun ? 8'd0 : drop_count_reg;

  always_ff @(posedge clk_10MHz or posedge rst) begin
    if (rst) begin
      overrun_reg    <= 1'b0;
      drop_count_reg <= '0;
    end else if (drop) begin
      overrun_reg    <= 1'b1;
      drop_count_reg <= (drop_base == 8'hFF) ? 8'hFF : drop_base + 8'd1;
    end else if (clear_overrun) begin
      overrun_reg    <= 1'b0;
      drop_count_reg <= '0;
    end
  end

  assign overrun    = overrun_reg;
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_sample_frame_streamer.sv
// tb_sample_frame_streamer -- directed bench with a beat/peak scoreboard.
// Main instance uses default parameters; a second instance with HOP=4 is
// used for the overrun scenarios.
module tb_sample_frame_streamer;

  localparam int N = 16;
  localparam int W = 12;

  logic clk_10MHz = 1'b0;
  always #5 clk_10MHz = ~clk_10MHz;

  logic                 rst;
  logic [N-1:0][W-1:0]  samples;
  logic                 sample_tick, enable, out_ready, clear_overrun;
  logic                 enable_h4, ready_h4;

  logic [W-1:0] out_data, frame_peak;
  logic [3:0]   out_idx;
  logic         out_valid, out_first, out_last, peak_valid, busy, overrun;
  logic [7:0]   drop_count;

  logic [W-1:0] out_data_h4, frame_peak_h4;
  logic [3:0]   out_idx_h4;
  logic         out_valid_h4, out_first_h4, out_last_h4, peak_valid_h4, busy_h4, overrun_h4;
  logic [7:0]   drop_count_h4;

  sample_frame_streamer dut (
    .clk_10MHz(clk_10MHz), .rst(rst), .samples(samples), .sample_tick(sample_tick),
    .enable(enable), .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
    .out_ready(out_ready), .out_first(out_first), .out_last(out_last),
    .frame_peak(frame_peak), .peak_valid(peak_valid), .busy(busy), .overrun(overrun),
    .drop_count(drop_count), .clear_overrun(clear_overrun)
  );

  sample_frame_streamer #(.HOP(4)) dut_h4 (
    .clk_10MHz(clk_10MHz), .rst(rst), .samples(samples), .sample_tick(sample_tick),
    .enable(enable_h4), .out_data(out_data_h4), .out_idx(out_idx_h4), .out_valid(out_valid_h4),
    .out_ready(ready_h4), .out_first(out_first_h4), .out_last(out_last_h4),
    .frame_peak(frame_peak_h4), .peak_valid(peak_valid_h4), .busy(busy_h4), .overrun(overrun_h4),
    .drop_count(drop_count_h4), .clear_overrun(clear_overrun)
  );

  typedef struct packed {
    logic [W-1:0] data;
    logic [3:0]   idx;
    logic         first;
    logic         last;
  } beat_t;

  beat_t        exp_q[$];
  logic [W-1:0] peak_q[$];
  int tests_run    = 0;
  int tests_failed = 0;
  int peaks_seen   = 0;
  int peaks_before = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_dev(input logic [W-1:0] s);
    return (s >= 12'd2048) ? s - 12'd2048 : 12'd2048 - s;
  endfunction

  // Expected beats and peak for a frame captured from the current window.
  task automatic push_frame();
    logic [W-1:0] pk;
    beat_t b;
    pk = '0;
    for (int i = 0; i < N; i++) begin
      b.data  = samples[i];
      b.idx   = 4'(i);
      b.first = (i == 0);
      b.last  = (i == N - 1);
      exp_q.push_back(b);
      if (ref_dev(samples[i]) > pk) pk = ref_dev(samples[i]);
    end
    peak_q.push_back(pk);
  endtask

  // One clock: scoreboard check at the falling edge, then advance to just
  // after the rising edge where the caller may drive new inputs.
  task automatic cycle();
    beat_t e;
    @(negedge clk_10MHz);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 32'(out_valid), 0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_idx", 32'(out_idx), 32'(e.idx));
        check("out_first", 32'(out_first), 32'(e.first));
        check("out_last", 32'(out_last), 32'(e.last));
        $display("[TB] beat idx=%0d data=%0d first=%0b last=%0b", out_idx, out_data, out_first, out_last);
      end
    end
    if (peak_valid) begin
      peaks_seen++;
      if (peak_q.size() == 0) check("unexpected_peak", 32'(peak_valid), 0);
      else                    check("frame_peak", 32'(frame_peak), 32'(peak_q.pop_front()));
      $display("[TB] peak frame_peak=%0d", frame_peak);
    end
    @(posedge clk_10MHz);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  // n consecutive ticks; the last one is the trigger of a new frame when push_last=1.
  task automatic ticks(input int n, input bit push_last);
    for (int t = 0; t < n; t++) begin
      sample_tick = 1'b1;
      if (push_last && t == n - 1) push_frame();
      cycle();
    end
    sample_tick = 1'b0;
  endtask

  task automatic restart_enable();
    enable = 1'b0;
    cycle();
    enable = 1'b1;
  endtask

  initial begin
    rst = 1'b1; sample_tick = 1'b0; enable = 1'b0; out_ready = 1'b0;
    clear_overrun = 1'b0; enable_h4 = 1'b0; ready_h4 = 1'b0;
    samples = '0;
    repeat (2) @(posedge clk_10MHz);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_out_idx", 32'(out_idx), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_frame_peak", 32'(frame_peak), 0);
    check("rst_peak_valid", 32'(peak_valid), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_drop_count", 32'(drop_count), 0);
    rst = 1'b0;
    cycle();

    // ---- fill: first frame needs 16 ticks ----
    for (int i = 0; i < N; i++) samples[i] = W'(i * 256);
    enable = 1'b1; out_ready = 1'b1;
    for (int t = 0; t < N - 1; t++) begin
      sample_tick = 1'b1;
      cycle();
      check("fill_no_valid", 32'(out_valid), 0);
    end
    sample_tick = 1'b1;
    push_frame();
    cycle();
    sample_tick = 1'b0;
    check("fill_valid", 32'(out_valid), 1);
    check("fill_busy", 32'(busy), 1);
    peaks_before = peaks_seen;
    run(N + 1);
    check("fill_drained", exp_q.size(), 0);
    check("fill_peak_once", peaks_seen - peaks_before, 1);
    check("fill_peak_2048", 32'(frame_peak), 2048);
    check("fill_idle", 32'(busy), 0);

    // ---- backpressure at idx 3 ----
    restart_enable();
    for (int i = 0; i < N; i++) samples[i] = W'(4095 - i * 100);
    ticks(N, 1'b1);
    run(3);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cycle();
      check("bp_idx_frozen", 32'(out_idx), 3);
      check("bp_data_frozen", 32'(out_data), 32'(exp_q[0].data));
    end
    out_ready = 1'b1;
    run(N - 3 + 1);
    check("bp_drained", exp_q.size(), 0);
    check("bp_peak_drained", peak_q.size(), 0);

    // ---- back-to-back frames ----
    restart_enable();
    for (int i = 0; i < N; i++) samples[i] = W'(100 * i + 5);
    ticks(N, 1'b1);
    for (int i = 0; i < N; i++) samples[i] = W'(4000 - 200 * i);
    ticks(N, 1'b1);
    check("b2b_valid", 32'(out_valid), 1);
    check("b2b_first", 32'(out_first), 1);
    check("b2b_idx0", 32'(out_idx), 0);
    check("b2b_overrun", 32'(overrun), 0);
    run(N + 1);
    check("b2b_drained", exp_q.size(), 0);
    check("b2b_peaks_drained", peak_q.size(), 0);
    check("b2b_drop_count", 32'(drop_count), 0);

    // ---- enable falls mid-frame ----
    restart_enable();
    for (int i = 0; i < N; i++) samples[i] = W'(2048 + 60 * i);
    ticks(N, 1'b1);
    run(2);
    check("en_idx2", 32'(out_idx), 2);
    enable = 1'b0;
    sample_tick = 1'b1;
    run(N - 2 + 1 + 40);
    sample_tick = 1'b0;
    check("en_drained", exp_q.size(), 0);
    check("en_peak_drained", peak_q.size(), 0);
    check("en_no_new_frame", 32'(busy), 0);

    // ---- reset mid-stream ----
    enable = 1'b1;
    for (int i = 0; i < N; i++) samples[i] = W'(1500 + 30 * i);
    ticks(N, 1'b1);
    run(7);
    check("rs_idx7", 32'(out_idx), 7);
    #2 rst = 1'b1;
    #1;
    check("rs_valid_low", 32'(out_valid), 0);
    check("rs_busy_low", 32'(busy), 0);
    exp_q.delete();
    peak_q.delete();
    @(posedge clk_10MHz);
    #1 rst = 1'b0;
    peaks_before = peaks_seen;
    for (int t = 0; t < N - 1; t++) begin
      sample_tick = 1'b1;
      cycle();
      check("rs_refill_no_valid", 32'(out_valid), 0);
    end
    check("rs_no_peak", peaks_seen - peaks_before, 0);
    sample_tick = 1'b1;
    push_frame();
    cycle();
    sample_tick = 1'b0;
    check("rs_new_frame", 32'(out_valid), 1);
    run(N + 1);
    check("rs_drained", exp_q.size(), 0);
    check("rs_one_peak", peaks_seen - peaks_before, 1);

    // ---- overrun with HOP=4 and no ready ----
    enable = 1'b0;
    enable_h4 = 1'b1; ready_h4 = 1'b0;
    ticks(N, 1'b0);
    check("ov_stream", 32'(out_valid_h4), 1);
    ticks(3, 1'b0);
    check("ov_none_yet", 32'(overrun_h4), 0);
    ticks(1, 1'b0);
    check("ov_set", 32'(overrun_h4), 1);
    check("ov_drop1", 32'(drop_count_h4), 1);
    check("ov_idx_held", 32'(out_idx_h4), 0);
    ticks(300 * 4, 1'b0);
    check("ov_sat255", 32'(drop_count_h4), 255);
    ticks(3, 1'b0);
    clear_overrun = 1'b1;
    ticks(1, 1'b0);
    clear_overrun = 1'b0;
    check("ov_clear_drop_cnt", 32'(drop_count_h4), 1);
    check("ov_clear_drop_flag", 32'(overrun_h4), 1);
    clear_overrun = 1'b1;
    cycle();
    clear_overrun = 1'b0;
    check("ov_clear_cnt", 32'(drop_count_h4), 0);
    check("ov_clear_flag", 32'(overrun_h4), 0);
    check("ov_main_untouched", 32'(overrun), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
